com_out_frame: RTL



---
 rtl/com_out_frame.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/com_out_frame.sv
// Command frame transmitter: sends cmd, data[7:0], data[15:8], data[23:16] over a valid/ready byte link.
// Defining COM_OUT_CMD_CHECK_EN restricts accepted command codes and enables the err pulse.
module com_out_frame #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send,
    input  logic [7:0]  cmd_in,
    input  logic [23:0] data_in,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [23:0] data_q, data_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    logic        cmd_ok;
    logic        handshake;
    logic [1:0]  idx_inc;
    logic [7:0]  next_byte;

`ifdef COM_OUT_CMD_CHECK_EN
    assign cmd_ok = cmd_in inside {[8'h01:8'h04], [8'h11:8'h14], 8'h51, 8'h52, 8'h61, 8'h62};
`else
    assign cmd_ok = 1'b1;
`endif

    assign handshake = tx_valid_q & tx_ready;
    assign idx_inc   = idx_q + 2'd1;

    // Byte that follows the one currently indexed by idx_q.
    always_comb begin
        case (idx_inc)
            2'd0:    next_byte = cmd_q;
            2'd1:    next_byte = data_q[7:0];
            2'd2:    next_byte = data_q[15:8];
            default: next_byte = data_q[23:16];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_cnt_d   = gap_cnt_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (send) begin
                    if (cmd_ok) begin
                        cmd_d      = cmd_in;
                        data_d     = data_in;
                        idx_d      = '0;
                        tx_data_d  = cmd_in;
                        tx_valid_d = 1'b1;
                        state_d    = SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            SEND: begin
                if (handshake) begin
                    if (idx_q == 2'd3) begin
                        tx_valid_d  = 1'b0;
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        idx_d       = '0;
                        state_d     = IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        idx_d     = idx_inc;
                        tx_data_d = next_byte;
                    end else begin
                        tx_valid_d = 1'b0;
                        gap_cnt_d  = GAP_LOAD;
                        state_d    = GAP;
                    end
                end
            end

            GAP: begin
                // Counter holds the remaining idle cycles including the current one.
                if (gap_cnt_q <= 8'd1) begin
                    gap_cnt_d  = '0;
                    idx_d      = idx_inc;
                    tx_data_d  = next_byte;
                    tx_valid_d = 1'b1;
                    state_d    = SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end

            default: begin
                tx_valid_d = 1'b0;
                idx_d      = '0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            gap_cnt_q   <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_cnt_q   <= gap_cnt_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign frame_cnt = frame_cnt_q;

endmodule
